// File: rtl/led_bar_pkg.sv
// Shared types and the LED decode helper for the stopwatch LED-bar stages.
//   state_t     : run/stop state of a bar stage
//   MODE_*      : display mode selectors
//   led_decode  : maps a step index to a 32-bit pattern; callers keep the low LED_W bits
package led_bar_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam int MODE_FILL   = 0;
    localparam int MODE_ONEHOT = 1;
    localparam int MODE_BINARY = 2;

    // idx never exceeds 32, so a 33-bit intermediate absorbs 1<<32 in fill mode.
    function automatic logic [31:0] led_decode(input logic [5:0] idx, input int mode);
        logic [32:0] one;
        logic [32:0] pat;
        one = 33'd1;
        pat = '0;
        case (mode)
            MODE_FILL:   pat = (one << idx) - one;
            MODE_ONEHOT: if (idx != 6'd0) pat = one << (idx - 6'd1);
            MODE_BINARY: pat = {27'd0, idx};
            default:     pat = '0;
        endcase
        return pat[31:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides a single-cycle tick strobe by DIV.
//   clk, rst_n : clock, async active-low reset
//   en         : count ticks only while high
//   clr        : synchronous clear of the count, overrides everything
//   tick       : timebase strobe
//   stb        : combinational, high on the cycle the DIV-th tick is accepted
module tick_prescaler #(
    parameter int DIV = 6000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic tick,
    output logic stb
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    always_comb begin
        hit   = en && tick && (cnt_q == TERM);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && tick) begin
            cnt_d = hit ? '0 : cnt_q + CW'(1);
        end
    end

    assign stb = hit && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_bar_timer.sv
// Stopwatch LED-bar stage: advances a bar display once per TICKS_PER_STEP ticks.
//   clk, rst_n     : clock, async active-low reset
//   tick           : timebase strobe
//   start, stop    : single-cycle run control (stop wins when both are high)
//   clear          : synchronous clear of prescaler, index, display and strobes
//   led            : registered LED pattern (MODE selects fill / one-hot / binary)
//   running        : high while RUNNING
//   step_stb       : one-cycle pulse per display step
//   wrap_stb       : one-cycle pulse when the display returns to empty
//
// state   | meaning
// STOPPED | ticks ignored, prescaler and index held
// RUNNING | ticks counted, display advances every TICKS_PER_STEP ticks
module led_bar_timer
    import led_bar_pkg::*;
#(
    parameter int TICKS_PER_STEP = 6000,
    parameter int LED_W          = 10,
    parameter int MODE           = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [LED_W-1:0] led,
    output logic             running,
    output logic             step_stb,
    output logic             wrap_stb
);

    localparam int               IDX_W    = $clog2(LED_W + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_W);

    state_t             state_q, state_d;
    logic               running_q, running_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic               step_hit;
    logic [31:0]        pat_full;

    tick_prescaler #(
        .DIV (TICKS_PER_STEP)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUNNING),
        .clr   (clear),
        .tick  (tick),
        .stb   (step_hit)
    );

    // Clear leaves the run state alone and masks start/stop for that cycle.
    always_comb begin
        state_d = state_q;
        if (!clear) begin
            case (state_q)
                STOPPED: if (start && !stop) state_d = RUNNING;
                RUNNING: if (stop)           state_d = STOPPED;
                default:                     state_d = STOPPED;
            endcase
        end
        running_d = (state_d == RUNNING);
    end

    always_comb begin
        idx_d    = idx_q;
        led_d    = led_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        pat_full = '0;
        if (clear) begin
            idx_d = '0;
            led_d = '0;
        end else if (step_hit) begin
            step_d = 1'b1;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
            pat_full = led_decode(6'(idx_d), MODE);
            led_d    = pat_full[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STOPPED;
            running_q <= 1'b0;
            idx_q     <= '0;
            led_q     <= '0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            idx_q     <= idx_d;
            led_q     <= led_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
        end
    end

    assign led      = led_q;
    assign running  = running_q;
    assign step_stb = step_q;
    assign wrap_stb = wrap_q;

endmodule

// File: tb/tb_led_bar_timer.sv
module tb_led_bar_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;

    logic [3:0] led0, led1, led2, led3;
    logic       run0, run1, run2, run3;
    logic       st0, st1, st2, st3;
    logic       wr0, wr1, wr2, wr3;
    logic [9:0] ledd;
    logic       rund, std, wrd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_bar_timer #(.TICKS_PER_STEP(4), .LED_W(4), .MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .led(led0), .running(run0), .step_stb(st0), .wrap_stb(wr0));
    led_bar_timer #(.TICKS_PER_STEP(4), .LED_W(4), .MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .led(led1), .running(run1), .step_stb(st1), .wrap_stb(wr1));
    led_bar_timer #(.TICKS_PER_STEP(4), .LED_W(4), .MODE(2)) d2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .led(led2), .running(run2), .step_stb(st2), .wrap_stb(wr2));
    led_bar_timer #(.TICKS_PER_STEP(4), .LED_W(4), .MODE(3)) d3 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .led(led3), .running(run3), .step_stb(st3), .wrap_stb(wr3));
    led_bar_timer dd (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .led(ledd), .running(rund), .step_stb(std), .wrap_stb(wrd));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic t, input logic s, input logic p, input logic c);
        tick  = t;
        start = s;
        stop  = p;
        clear = c;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_fill[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    logic [3:0] exp_hot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [3:0] exp_bin [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0000};

    initial begin
        int steps;
        int k;

        // reset values while rst_n is held low
        #12;
        check("rst_led0", 32'(led0), 32'h0);
        check("rst_run0", 32'(run0), 32'h0);
        check("rst_stb0", 32'(st0), 32'h0);
        check("rst_wrap0", 32'(wr0), 32'h0);
        check("rst_ledd", 32'(ledd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // full display cycle in all three modes plus the illegal mode
        drive(0, 1, 0, 0);
        check("run_after_start", 32'(run0), 32'h1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0);
            k = i / 4;
            if ((i % 4) == 3) begin
                check($sformatf("fill_led_%0d", k), 32'(led0), 32'(exp_fill[k]));
                check($sformatf("hot_led_%0d", k), 32'(led1), 32'(exp_hot[k]));
                check($sformatf("bin_led_%0d", k), 32'(led2), 32'(exp_bin[k]));
                check($sformatf("step_%0d", k), 32'(st0), 32'h1);
                check($sformatf("wrap_%0d", k), 32'(wr0), (k == 4) ? 32'h1 : 32'h0);
                check($sformatf("bad_mode_led_%0d", k), 32'(led3), 32'h0);
                check($sformatf("bad_mode_step_%0d", k), 32'(st3), 32'h1);
            end else begin
                check($sformatf("no_step_t%0d", i), 32'(st0), 32'h0);
            end
        end

        // pause keeps partial count, paused ticks ignored
        do_reset();
        steps = 0;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 0); if (st0) steps++; end
        drive(0, 0, 1, 0);
        check("run_after_stop", 32'(run0), 32'h0);
        for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0); if (st0) steps++; end
        drive(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 0); if (st0) steps++; end
        check("pause_steps", 32'(steps), 32'd1);
        check("pause_led", 32'(led0), 32'h1);

        // start+stop together, tick coincident with start
        do_reset();
        drive(0, 1, 1, 0);
        check("start_stop_run", 32'(run0), 32'h0);
        drive(1, 1, 0, 0);
        check("start_tick_run", 32'(run0), 32'h1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        check("start_tick_led3", 32'(led0), 32'h0);
        check("start_tick_stb3", 32'(st0), 32'h0);
        drive(1, 0, 0, 0);
        check("start_tick_led4", 32'(led0), 32'h1);
        check("start_tick_stb4", 32'(st0), 32'h1);

        // clear coincident with a step
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0);
        check("pre_clear_led", 32'(led0), 32'h7);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        check("clear_led", 32'(led0), 32'h0);
        check("clear_stb", 32'(st0), 32'h0);
        check("clear_wrap", 32'(wr0), 32'h0);
        check("clear_run", 32'(run0), 32'h1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        check("post_clear_led3", 32'(led0), 32'h0);
        drive(1, 0, 0, 0);
        check("post_clear_led4", 32'(led0), 32'h1);

        // async reset mid-prescale, observed before the next clock edge
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led0), 32'h0);
        check("async_rst_run", 32'(run0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // default parameters: 6000 ticks per step, 10 LEDs, fill mode
        drive(0, 1, 0, 0);
        steps = 0;
        for (int i = 1; i <= 66000; i++) begin
            drive(1, 0, 0, 0);
            if (std) steps++;
            if (i == 5999)  check("dflt_led_5999", 32'(ledd), 32'h0);
            if (i == 6000)  check("dflt_led_6000", 32'(ledd), 32'h1);
            if (i == 60000) begin
                check("dflt_led_60000", 32'(ledd), 32'h3ff);
                check("dflt_wrap_60000", 32'(wrd), 32'h0);
            end
            if (i == 66000) begin
                check("dflt_led_66000", 32'(ledd), 32'h0);
                check("dflt_wrap_66000", 32'(wrd), 32'h1);
            end
        end
        check("dflt_steps", 32'(steps), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_bar_timer.md
Name: led_bar_timer

Overview:
- Parametrised stopwatch LED-bar timer: divides an incoming timebase strobe by a programmable ratio and advances an LED_W-wide bar display once per step.
- Adds start/stop/clear control, selectable display mode, and step/wrap strobes over the fixed-width minutes bar counter.
- Sits between the stopwatch timebase (100 Hz tick) and the board LEDs; strobes may cascade into further display stages.

Parameters:
- TICKS_PER_STEP, 6000, input ticks per display step (>=2)
- LED_W, 10, LED count (2..32)
- MODE, 0, display mode: 0 = fill bar, 1 = walking one-hot, 2 = binary step index

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- tick  in  1  single-cycle timebase strobe
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- clear  in  1  synchronous clear of counts
- led  out  LED_W  registered LED pattern
- running  out  1  high in RUNNING state
- step_stb  out  1  one-cycle pulse per display step
- wrap_stb  out  1  one-cycle pulse when the display wraps to empty

Behaviour:
- Reset (rst_n low, async): state STOPPED, prescaler 0, step index idx 0, led 0, running 0, step_stb 0, wrap_stb 0.
- FSM states: STOPPED, RUNNING.
  - STOPPED -> RUNNING on start && !stop.
  - RUNNING -> STOPPED on stop.
  - start while RUNNING: ignored. stop while STOPPED: ignored. start && stop in the same cycle: stop wins.
- running = (state == RUNNING), registered.
- Prescaler: width $clog2(TICKS_PER_STEP).
  - Counts only when state == RUNNING at the clock edge and tick is high.
  - On reaching TICKS_PER_STEP-1 with tick: returns to 0 and issues a step.
  - Tick in the same cycle as a start is not counted, because state is still STOPPED.
  - STOPPED holds prescaler and idx (pause preserves partial progress).
- Step: idx runs 0..LED_W.
  - If idx < LED_W: idx+1, step_stb = 1.
  - If idx == LED_W: idx = 0, step_stb = 1, wrap_stb = 1.
  - One display cycle is LED_W+1 steps, including the empty state.
- led decode, registered, updated on the same edge as idx:
  - MODE 0: (1<<idx)-1 (idx == LED_W gives all ones).
  - MODE 1: 0 when idx == 0, else 1<<(idx-1).
  - MODE 2: idx zero-extended or truncated to LED_W.
- Latency: led, step_stb and wrap_stb become valid the cycle after the edge that samples the final tick. Strobes are exactly 1 cycle wide.
- clear: highest priority over tick, start and stop.
  - Zeroes prescaler, idx, led and strobes.
  - State is unchanged; clear while RUNNING continues counting from 0 next cycle.
- Simultaneous clear and step: clear wins, no strobes.
- Width rule: all internal arithmetic is unsigned. MODE 0/1 shift amounts are bounded by LED_W, so no out-of-range shift can occur.
- Illegal MODE (>2): led drives 0; counting is unaffected.
- Reset asserted mid-step: everything returns to reset values immediately, without waiting for clk.

Decomposition:
- Package led_bar_pkg:
  - state_t enum {STOPPED, RUNNING}
  - mode constants MODE_FILL = 0, MODE_ONEHOT = 1, MODE_BINARY = 2
  - function that decodes idx to the led pattern for a given mode
- Sub-module tick_prescaler (params DIV):
  - inputs clk, rst_n, en, clr, tick; output stb
  - reused by other stopwatch display stages

Test Plan (TICKS_PER_STEP=4, LED_W=4 unless stated):
- Reset then start, 4 ticks -> step_stb once, led=0001 (MODE 0); 16 more ticks -> led 0011, 0111, 1111, then 0000 with wrap_stb=1 on the same cycle.
- MODE 1, 20 ticks while running -> led sequence 0001, 0010, 0100, 1000, 0000; MODE 2 same stimulus -> 0001, 0010, 0011, 0100, 0000.
- Start, 2 ticks, stop, 5 ticks, start, 2 ticks -> exactly one step_stb, led=0001 (paused ticks ignored, partial count kept).
- Start and stop asserted together in STOPPED -> running stays 0. Tick coincident with start -> not counted; 4 further ticks are needed for the first step.
- Running with led=0111, clear together with the 4th tick -> led=0000, no strobes, running=1; 4 more ticks -> led=0001.
- Default params: start, 6000 ticks -> led=0000000001; 60000 ticks -> led=1111111111; tick 66000 -> led=0, wrap_stb. Async rst_n pulse mid-prescale -> all outputs 0 before the next clk edge.
